hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers; the next-generation multicycle part of the datapath ALU.
- Supports signed and unsigned MULT/DIV, plus MFHI/MFLO/MTHI/MTLO.
- Adds over the previous generation: WIDTH generalisation, signed modes, an explicit start/busy/done handshake, and defined divide-by-zero behaviour.
- Sits beside the combinational ALU. The top level muxes Output when Signal is MFHI or MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width. Legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset.
- dataA  in  WIDTH  Multiplicand / dividend / MTHI-MTLO source.
- dataB  in  WIDTH  Multiplier / divisor.
- Signal  in  6  Function code: MFHI=16, MTHI=17, MFLO=18, MTLO=19, MULT=24, MULTU=25, DIV=26, DIVU=27.
- start  in  1  Command strobe. Sampled only when busy=0.
- busy  out  1  High from the cycle after an accepted MULT/DIV start until done drops.
- done  out  1  One-cycle pulse; HI/LO already hold the result during this cycle.
- div_by_zero  out  1  Set when a DIV/DIVU completes with dataB=0; cleared on the next accepted start.
- Output  out  WIDTH  HI if Signal=16, LO if Signal=18, else 0. Combinational from the registers.

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE.
  - HI, LO, counter, working registers, busy, done and div_by_zero all go to 0.
  - Reset overrides every other event, including mid-operation. An aborted operation never asserts done and never writes HI/LO.
- States: IDLE, RUN, FIX, DONE. busy = (state != IDLE).
- IDLE:
  - start=1 with Signal in {24..27}:
    - Latch operand magnitudes. For signed codes with a negative operand, take its two's complement. For unsigned codes, use the raw value.
    - Latch the result signs (product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA).
    - Clear the counter and div_by_zero. Go to RUN.
  - start=1 with Signal=17: HI <= dataA at that edge. Stay IDLE, no done.
  - start=1 with Signal=19: LO <= dataA at that edge. Stay IDLE, no done.
  - start=1 with any other Signal: ignored.
- RUN (exactly WIDTH cycles, one bit per cycle):
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division. Shift the remainder:quotient pair left 1. If remainder >= divisor, subtract and set the quotient LSB.
  - When counter = WIDTH-1, go to FIX.
- FIX (1 cycle): apply sign correction (negate where the latched sign is 1) and write HI/LO at the exit edge.
  - Multiply: {HI,LO} = 2*WIDTH-bit product.
  - Divide: LO = quotient, rounded toward zero. HI = remainder, with the dividend's sign.
  - Divide by zero (dataB latched = 0), signed or unsigned: LO = all ones, HI = dataA (original value, uncorrected), div_by_zero <= 1.
  - Signed overflow (MIN / -1): LO = MIN, HI = 0. This falls out of the magnitude method with no special case.
- DONE (1 cycle): done=1, then IDLE.
- Latency: accepted-start edge = cycle 0. done is high during cycle WIDTH+2. A new command can be accepted at the edge ending the DONE cycle + 1, i.e. the first IDLE cycle.
- While busy:
  - start is ignored for all codes, including MTHI/MTLO.
  - dataA/dataB may change freely; operands were latched at start.
- MFHI/MFLO while busy return the previous HI/LO. Results become visible only from the DONE cycle onward.
- Arithmetic is modulo 2^WIDTH per register. No overflow flag for multiply.

Test Plan (WIDTH=32 unless noted):
1. MULTU dataA=0xFFFFFFFF, dataB=0xFFFFFFFF, start at cycle 0
   -> done high only in cycle 34; MFHI=0xFFFFFFFE, MFLO=0x00000001; busy high cycles 1-34.
2. MULT -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then DIVU 100 / 7 -> LO=14, HI=2.
3. DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, div_by_zero=1. Next accepted MULTU 2×3 clears the flag at its start edge; result HI=0, LO=6.
4. Collisions and moves:
   - MULTU 4×5 started; at cycle 5 pulse start with DIVU 9/3 and with MTHI 0xDEADBEEF -> both ignored.
   - Final HI=0, LO=20; exactly one done pulse.
   - Then MTHI 0x12345678 -> MFHI=0x12345678 next cycle, done stays 0.
5. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
   - Separately, start DIVU 100/7 and drive reset=0 at cycle 10 -> busy=0 and HI=LO=0 after that edge; no done pulse ever.
6. WIDTH=8 instance: MULTU 200×200 -> done in cycle 10, HI=0x9C, LO=0x40. DIV -128 / 3 -> LO=0xD6 (-42), HI=0xFE (-2).

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative signed/unsigned multiply/divide unit with HI/LO registers
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Output
);

  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MTHI = 6'd17;
  localparam logic [5:0] F_MFLO = 6'd18;
  localparam logic [5:0] F_MTLO = 6'd19;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   orig_a;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               op_div;
  logic               sign_q;
  logic               sign_r;

  logic               is_muldiv;
  logic               neg_a, neg_b;
  logic               accept;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Command decode and operand magnitude extraction (codes 24..27, bit0 = unsigned, bit1 = divide)
  always_comb begin
    is_muldiv = (Signal[5:2] == 4'b0110);
    neg_a     = ~Signal[0] & dataA[WIDTH-1];
    neg_b     = ~Signal[0] & dataB[WIDTH-1];
    accept    = (state == S_IDLE) & start & is_muldiv;
    mag_a_in  = neg_a ? (~dataA + 1'b1) : dataA;
    mag_b_in  = neg_b ? (~dataB + 1'b1) : dataB;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and status outputs
  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide, plus final sign correction
  always_comb begin
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    div_rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge     = (div_rem_sh >= {1'b0, mag_b});
    div_diff   = div_rem_sh[WIDTH-1:0] - mag_b;
    if (op_div) begin
      if (div_ge) begin
        acc_step = {div_diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    prod_fix = sign_q ? (~acc + 1'b1) : acc;
    quo_fix  = sign_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = sign_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // Datapath: operand latch, iteration, HI/LO writeback and register moves
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi          <= '0;
      lo          <= '0;
      mag_b       <= '0;
      orig_a      <= '0;
      acc         <= '0;
      cnt         <= '0;
      op_div      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc         <= {{WIDTH{1'b0}}, mag_a_in};
            mag_b       <= mag_b_in;
            orig_a      <= dataA;
            op_div      <= Signal[1];
            sign_q      <= neg_a ^ neg_b;
            sign_r      <= neg_a;
            cnt         <= '0;
            div_by_zero <= 1'b0;
          end else if (start && Signal == F_MTHI) begin
            hi <= dataA;
          end else if (start && Signal == F_MTLO) begin
            lo <= dataA;
          end
        end
        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!op_div) begin
            {hi, lo} <= prod_fix;
          end else if (mag_b == '0) begin
            lo          <= '1;
            hi          <= orig_a;
            div_by_zero <= 1'b1;
          end else begin
            lo <= quo_fix;
            hi <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // Register read mux for MFHI/MFLO
  always_comb begin
    Output = '0;
    if (Signal == F_MFHI) begin
      Output = hi;
    end else if (Signal == F_MFLO) begin
      Output = lo;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b, out;
  logic [5:0]  sig;
  logic        st, busy, done, dz;
  logic [7:0]  a8, b8, out8;
  logic [5:0]  sig8;
  logic        st8, busy8, done8, dz8;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic dz_c1;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .dataA(a), .dataB(b), .Signal(sig), .start(st),
    .busy(busy), .done(done), .div_by_zero(dz), .Output(out)
  );

  hilo_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .dataA(a8), .dataB(b8), .Signal(sig8), .start(st8),
    .busy(busy8), .done(done8), .div_by_zero(dz8), .Output(out8)
  );

  // Count done pulses of the 32-bit instance, sampled mid-cycle
  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [5:0] s, output logic [31:0] v);
    sig = s;
    #1;
    v = out;
  endtask

  task automatic rd8(input logic [5:0] s, output logic [7:0] v);
    sig8 = s;
    #1;
    v = out8;
  endtask

  task automatic run32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [5:0] sv, input logic [31:0] ehi, input logic [31:0] elo);
    int got;
    logic [31:0] v;
    a = av; b = bv; sig = sv; st = 1'b1;
    tick();
    st = 1'b0;
    dz_c1 = dz;
    chk({tag, "_busy_c1"}, 64'(busy), 64'd1);
    got = -1;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        got = n;
        break;
      end
      tick();
    end
    chk({tag, "_done_cycle"}, 64'(got), 64'd34);
    rd(6'd16, v);
    chk({tag, "_hi"}, 64'(v), 64'(ehi));
    rd(6'd18, v);
    chk({tag, "_lo"}, 64'(v), 64'(elo));
    tick();
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_done"}, 64'(done), 64'd0);
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [5:0] sv, input logic [7:0] ehi, input logic [7:0] elo);
    int got;
    logic [7:0] v;
    a8 = av; b8 = bv; sig8 = sv; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    got = -1;
    for (int n = 1; n <= 30; n++) begin
      if (done8) begin
        got = n;
        break;
      end
      tick();
    end
    chk({tag, "_done_cycle"}, 64'(got), 64'd10);
    rd8(6'd16, v);
    chk({tag, "_hi"}, 64'(v), 64'(ehi));
    rd8(6'd18, v);
    chk({tag, "_lo"}, 64'(v), 64'(elo));
    tick();
    chk({tag, "_idle_busy"}, 64'(busy8), 64'd0);
  endtask

  initial begin
    logic [31:0] v;
    int got;
    int snap;

    reset = 1'b0;
    a = '0; b = '0; sig = '0; st = 1'b0;
    a8 = '0; b8 = '0; sig8 = '0; st8 = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    rd(6'd16, v);
    chk("rst_hi", 64'(v), 64'd0);
    rd(6'd18, v);
    chk("rst_lo", 64'(v), 64'd0);
    rd(6'd0, v);
    chk("rst_out_other", 64'(v), 64'd0);

    // Unsigned full-range multiply
    run32("multu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd25, 32'hFFFFFFFE, 32'h00000001);

    // Signed multiply and divide, unsigned divide
    run32("mult_m3x7", 32'hFFFFFFFD, 32'd7, 6'd24, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run32("div_m7d2", 32'hFFFFFFF9, 32'd2, 6'd26, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run32("divu_100d7", 32'd100, 32'd7, 6'd27, 32'd2, 32'd14);

    // Divide by zero and flag clearing
    run32("divu_by0", 32'd5, 32'd0, 6'd27, 32'd5, 32'hFFFFFFFF);
    chk("divu_by0_flag", 64'(dz), 64'd1);
    run32("multu_2x3", 32'd2, 32'd3, 6'd25, 32'd0, 32'd6);
    chk("dz_clear_at_start", 64'(dz_c1), 64'd0);
    chk("dz_clear_after", 64'(dz), 64'd0);

    // Start collisions while busy are ignored
    done_cnt = 0;
    a = 32'd4; b = 32'd5; sig = 6'd25; st = 1'b1;
    tick();
    st = 1'b0;
    got = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done && got < 0) got = n;
      if (n == 11) chk("busy_mfhi_prev", 64'(out), 64'd0);
      if (n == 5) begin
        a = 32'd9; b = 32'd3; sig = 6'd27; st = 1'b1;
      end else if (n == 6) begin
        a = 32'hDEADBEEF; sig = 6'd17; st = 1'b1;
      end else if (n == 10) begin
        sig = 6'd16; st = 1'b0;
      end else begin
        st = 1'b0;
      end
      tick();
    end
    st = 1'b0;
    chk("collide_done_cycle", 64'(got), 64'd34);
    chk("collide_done_count", 64'(done_cnt), 64'd1);
    rd(6'd16, v);
    chk("collide_hi", 64'(v), 64'd0);
    rd(6'd18, v);
    chk("collide_lo", 64'(v), 64'd20);

    // MTHI while idle
    a = 32'h12345678; sig = 6'd17; st = 1'b1;
    tick();
    st = 1'b0;
    chk("mthi_done", 64'(done), 64'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    rd(6'd16, v);
    chk("mthi_hi", 64'(v), 64'h12345678);
    a = 32'h0000BEEF; sig = 6'd19; st = 1'b1;
    tick();
    st = 1'b0;
    rd(6'd18, v);
    chk("mtlo_lo", 64'(v), 64'h0000BEEF);

    // Signed overflow divide
    run32("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 6'd26, 32'd0, 32'h80000000);

    // Reset mid-operation aborts without done or writeback
    a = 32'hAAAA5555; sig = 6'd17; st = 1'b1;
    tick();
    st = 1'b0;
    snap = done_cnt;
    a = 32'd100; b = 32'd7; sig = 6'd27; st = 1'b1;
    tick();
    st = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    reset = 1'b0;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    rd(6'd16, v);
    chk("abort_hi", 64'(v), 64'd0);
    rd(6'd18, v);
    chk("abort_lo", 64'(v), 64'd0);
    reset = 1'b1;
    for (int n = 0; n < 45; n++) tick();
    chk("abort_no_done", 64'(done_cnt), 64'(snap));

    // 8-bit instance
    run8("w8_multu", 8'd200, 8'd200, 6'd25, 8'h9C, 8'h40);
    run8("w8_div_m128d3", 8'h80, 8'd3, 6'd26, 8'hFE, 8'hD6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
